text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
// PURPOSE
//   Write side of the 80x30 text buffer. Accepts a byte stream (e.g. from a UART receiver),
//   interprets printable ASCII and a few control codes, and drives port A of text_memory.
//   Port B continues to feed the glyph/pixel path.
//   Maintains a cursor and owns line-wrap and screen/line clearing. Character cell address = row*COLS + col.
// PARAMETERS
//   COLS       80     columns per row (x[9:3] of a 640-wide raster)
//   ROWS       30     rows per screen (y[8:4] of a 480-high raster)
//   ADDR_W     12     text_memory address width; must satisfy COLS*ROWS <= 2**ADDR_W
//   FILL_CHAR  8'h20  byte written by every clear or erase operation
// PORTS
//   clk         in   1       system clock (same clock as text_memory clka)
//   rst_n       in   1       synchronous reset, active-low
//   char_in     in   8       input byte
//   char_valid  in   1       char_in is valid
//   char_ready  out  1       writer can accept; transfer happens when char_valid & char_ready at posedge
//   wea         out  1       text_memory port A write enable
//   addra       out  ADDR_W  text_memory port A address
//   dina        out  8       text_memory port A data
//   cursor_col  out  7       current column, 0..COLS-1
//   cursor_row  out  5       current row, 0..ROWS-1
//   busy        out  1       a clear operation is in progress (equals ~char_ready)
// BEHAVIOUR
//   Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n).
//   Reset values: wea=0, addra=0, dina=0, cursor=(0,0), char_ready=1, busy=0, state=IDLE.
//     With CLEAR_ON_RESET_EN: state=CLR_SCREEN, char_ready=0, busy=1.
//   Output timing: all outputs are registered. A byte accepted at edge N gives wea/addra/dina valid in cycle N+1.
//     wea stays high for exactly one cycle per write.
//   States
//     IDLE        char_ready=1; decodes each accepted byte.
//     CLR_LINE    char_ready=0; writes FILL_CHAR to COLS cells of cursor_row, col 0..COLS-1,
//                 one cell per cycle; then returns to IDLE.
//     CLR_SCREEN  char_ready=0; writes FILL_CHAR to addresses 0..COLS*ROWS-1, one per cycle;
//                 then cursor=(0,0) and returns to IDLE.
//   Decode in IDLE
//     0x20..0x7E  write byte at (row,col), then advance col.
//                 At col=COLS-1: col=0 and row+1 (newline rule).
//     0x0A (LF)   col=0, row+1 (newline rule); no write.
//     0x0D (CR)   col=0; no write.
//     0x08 (BS)   if col>0: col-1 and write FILL_CHAR at the new position. If col=0: no-op, no write.
//     0x0C (FF)   enter CLR_SCREEN.
//     others      accepted and dropped: no write, no cursor change.
//   Newline rule
//     row<ROWS-1:  row+1, remain in IDLE.
//     row=ROWS-1:  row=0, enter CLR_LINE for row 0 (wrap, no scroll; port A is write-only).
//     Any other row reached by a newline is not cleared.
//   Boundaries
//     char_valid held during a clear: byte is stalled, not lost.
//     A printable byte at (ROWS-1, COLS-1) writes first, then CLR_LINE starts in the next cycle.
//     Reset mid-clear aborts immediately to the reset values; a partially cleared buffer is acceptable.
//     Address arithmetic is done at ADDR_W bits; the maximum address is COLS*ROWS-1 = 2399, with no overflow.
// CONFIGURATION
//   CLEAR_ON_RESET_EN
//     defined:  after reset, CLR_SCREEN runs (COLS*ROWS cycles, char_ready=0) before the first byte is accepted.
//     undefined: buffer contents after reset are whatever the memory holds (init file);
//                char_ready=1 in the first cycle after reset.
// STRUCTURE
//   Shared package text_pkg
//     TEXT_COLS, TEXT_ROWS, TEXT_ADDR_W
//     control codes ASCII_LF, ASCII_CR, ASCII_BS, ASCII_FF, ASCII_SPACE
//     state encoding (IDLE, CLR_LINE, CLR_SCREEN).
//     The framebuffer read path uses the same COLS/ROWS constants.
//   One sub-module: text_cursor
//     col/row counters with advance, newline, CR and BS controls.
//     Wrap flag output; registered address = row*COLS + col.
//   The state machine and the clear counter stay in the top module.
// TESTING
//   1. Reset, then send "AB" -> two one-cycle writes: (addra=0, dina=0x41) and (addra=1, dina=0x42);
//      cursor=(0,2).
//   2. Send 80 x 'x' then 'y' -> 'y' written at addra=80; cursor=(1,1).
//   3. Send CR, LF, BS at col 0 -> no wea pulses; cursor=(1,0) after the LF.
//      Then 'z', BS -> writes 'z' at addra=80, then FILL_CHAR at addra=80; cursor=(1,0).
//   4. Move cursor to row 29, send LF -> cursor=(0,0); exactly 80 writes of 0x20 to addra 0..79;
//      char_ready low for 80 cycles; a byte held valid meanwhile is written at addra=0 afterwards.
//   5. Send FF -> 2400 consecutive writes of 0x20 to addra 0..2399; cursor=(0,0); char_ready returns high.
//      Assert rst_n=0 at write 1000 -> wea=0 the next cycle and no further writes.
//   6. With CLEAR_ON_RESET_EN defined -> 2400 clear writes follow reset release before the first
//      char_ready=1. Without it -> char_ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/text_pkg.sv
// Shared text-mode constants, control codes and writer state encoding.
// The framebuffer read path uses the same COLS/ROWS constants.
package text_pkg;

  localparam int TEXT_COLS   = 80;
  localparam int TEXT_ROWS   = 30;
  localparam int TEXT_ADDR_W = 12;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row counters for the text console, with a registered
// cell address (row*COLS + col) kept in step with the counters.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS,
  parameter int ADDR_W = TEXT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              newline,
  input  logic              cr,
  input  logic              bs,
  input  logic              home,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic              at_eol,
  output logic              wrap
);

  logic [6:0]        col_reg, col_next;
  logic [4:0]        row_reg, row_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [4:0]        row_inc;

  assign at_eol  = (col_reg == 7'(COLS - 1));
  // A newline taken from the current row would wrap back to row 0.
  assign wrap    = (row_reg == 5'(ROWS - 1));
  assign row_inc = wrap ? 5'd0 : row_reg + 5'd1;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (home) begin
      col_next = 7'd0;
      row_next = 5'd0;
    end else if (advance) begin
      if (at_eol) begin
        col_next = 7'd0;
        row_next = row_inc;
      end else begin
        col_next = col_reg + 7'd1;
      end
    end else if (newline) begin
      col_next = 7'd0;
      row_next = row_inc;
    end else if (cr) begin
      col_next = 7'd0;
    end else if (bs && (col_reg != 7'd0)) begin
      col_next = col_reg - 7'd1;
    end
    addr_next = ADDR_W'(row_next) * ADDR_W'(COLS) + ADDR_W'(col_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg  <= 7'd0;
      row_reg  <= 5'd0;
      addr_reg <= '0;
    end else begin
      col_reg  <= col_next;
      row_reg  <= row_next;
      addr_reg <= addr_next;
    end
  end

  assign col  = col_reg;
  assign row  = row_reg;
  assign addr = addr_reg;

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream writer for the 80x30 text buffer (drives text_memory port A).
// Optional CLEAR_ON_RESET_EN: clear the whole screen after every reset.
module text_console_writer
  import text_pkg::*;
#(
  parameter int         COLS      = TEXT_COLS,
  parameter int         ROWS      = TEXT_ROWS,
  parameter int         ADDR_W    = TEXT_ADDR_W,
  parameter logic [7:0] FILL_CHAR = ASCII_SPACE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

`ifdef CLEAR_ON_RESET_EN
  localparam state_t     RESET_STATE = CLR_SCREEN;
  localparam logic       RESET_READY = 1'b0;
`else
  localparam state_t     RESET_STATE = IDLE;
  localparam logic       RESET_READY = 1'b1;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              wea_reg, wea_next;
  logic [ADDR_W-1:0] addra_reg, addra_next;
  logic [7:0]        dina_reg, dina_next;
  logic              ready_reg;

  logic              cur_advance, cur_newline, cur_cr, cur_bs, cur_home;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_at_eol, cur_wrap;
  logic              accept;

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (cur_advance),
    .newline (cur_newline),
    .cr      (cur_cr),
    .bs      (cur_bs),
    .home    (cur_home),
    .col     (cursor_col),
    .row     (cursor_row),
    .addr    (cur_addr),
    .at_eol  (cur_at_eol),
    .wrap    (cur_wrap)
  );

  assign accept = char_valid && ready_reg;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    wea_next     = 1'b0;
    addra_next   = addra_reg;
    dina_next    = dina_reg;
    cur_advance  = 1'b0;
    cur_newline  = 1'b0;
    cur_cr       = 1'b0;
    cur_bs       = 1'b0;
    cur_home     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_printable(char_in)) begin
            wea_next    = 1'b1;
            addra_next  = cur_addr;
            dina_next   = char_in;
            cur_advance = 1'b1;
            // Writing the very last cell wraps to row 0, which is cleared next.
            if (cur_at_eol && cur_wrap) begin
              state_next   = CLR_LINE;
              clr_cnt_next = '0;
            end
          end else begin
            case (char_in)
              ASCII_LF: begin
                cur_newline = 1'b1;
                if (cur_wrap) begin
                  state_next   = CLR_LINE;
                  clr_cnt_next = '0;
                end
              end
              ASCII_CR: cur_cr = 1'b1;
              ASCII_BS: begin
                if (cursor_col != 7'd0) begin
                  cur_bs     = 1'b1;
                  wea_next   = 1'b1;
                  addra_next = cur_addr - ADDR_W'(1);
                  dina_next  = FILL_CHAR;
                end
              end
              ASCII_FF: begin
                state_next   = CLR_SCREEN;
                clr_cnt_next = '0;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        // Cursor already sits at column 0 of the row being cleared.
        wea_next     = 1'b1;
        addra_next   = cur_addr + clr_cnt_reg;
        dina_next    = FILL_CHAR;
        clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
        if (clr_cnt_reg == ADDR_W'(COLS - 1)) begin
          state_next = IDLE;
        end
      end
      CLR_SCREEN: begin
        wea_next     = 1'b1;
        addra_next   = clr_cnt_reg;
        dina_next    = FILL_CHAR;
        clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
        if (clr_cnt_reg == ADDR_W'(COLS * ROWS - 1)) begin
          cur_home   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RESET_STATE;
      ready_reg   <= RESET_READY;
      clr_cnt_reg <= '0;
      wea_reg     <= 1'b0;
      addra_reg   <= '0;
      dina_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      ready_reg   <= (state_next == IDLE);
      clr_cnt_reg <= clr_cnt_next;
      wea_reg     <= wea_next;
      addra_reg   <= addra_next;
      dina_reg    <= dina_next;
    end
  end

  assign char_ready = ready_reg;
  assign busy       = ~ready_reg;
  assign wea        = wea_reg;
  assign addra      = addra_reg;
  assign dina       = dina_reg;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: behavioural cursor/write model,
// per-cycle compare at negedge, directed literal checks and random byte stream.
module tb_text_console_writer;
  import text_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready, wea, busy;
  logic [11:0] addra;
  logic [7:0]  dina;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  always #5 clk = ~clk;

  text_console_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  int checks = 0;
  int failures = 0;

  // Model state: cursor and the queue of expected port-A cycles
  // (-1 = a cycle with no write, otherwise addr<<8 | data).
  int m_col = 0, m_row = 0;
  int exp_q[$];
  bit pending_clr = 1'b0;
  bit armed = 1'b0;

  int wr_count = 0, fill_count = 0, ready_low_count = 0;
  int last_addr = -1, last_data = -1;

  function automatic void chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_write(input int a, input int d);
    exp_q.push_back((a << 8) | d);
  endfunction

  function automatic void model_newline(input bit from_lf);
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      m_row = 0;
      if (from_lf) exp_q.push_back(-1);
      for (int i = 0; i < COLS; i++) model_write(i, 8'h20);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      model_write(m_row * COLS + m_col, int'(b));
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_newline(1'b0);
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      model_newline(1'b1);
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        model_write(m_row * COLS + m_col, 8'h20);
      end
    end else if (b == 8'h0C) begin
      exp_q.push_back(-1);
      for (int i = 0; i < NCELL; i++) model_write(i, 8'h20);
      m_col = 0;
      m_row = 0;
    end
  endfunction

  always @(negedge clk) begin
    int e;
    bit exp_ready;
    if (armed) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e < 0) chk(wea === 1'b0, "idle_cycle_wea", int'(wea), 0);
        else chk(wea === 1'b1 && int'({addra, dina}) == e, "write",
                 wea ? int'({addra, dina}) : -1, e);
      end else begin
        chk(wea === 1'b0, "unexpected_write", wea ? int'({addra, dina}) : 0, 0);
      end
      exp_ready = (exp_q.size() == 0) && !pending_clr;
      chk(char_ready === exp_ready, "char_ready", int'(char_ready), int'(exp_ready));
      chk(busy === ~char_ready, "busy", int'(busy), int'(~char_ready));
      if (exp_ready)
        chk(int'(cursor_row) == m_row && int'(cursor_col) == m_col, "cursor",
            int'(cursor_row) * 100 + int'(cursor_col), m_row * 100 + m_col);
      if (wea) begin
        wr_count++;
        last_addr = int'(addra);
        last_data = int'(dina);
        if (dina == 8'h20) fill_count++;
      end
      if (!char_ready) ready_low_count++;
    end
    if (!rst_n) begin
      exp_q.delete();
      m_col = 0;
      m_row = 0;
`ifdef CLEAR_ON_RESET_EN
      pending_clr = 1'b1;
`endif
      armed = 1'b1;
    end else if (armed) begin
      if (pending_clr) begin
        for (int i = 0; i < NCELL; i++) model_write(i, 8'h20);
        pending_clr = 1'b0;
      end else if (char_valid && char_ready) begin
        model_byte(char_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit acc = 1'b0;
    char_in = b;
    char_valid = 1'b1;
    for (int i = 0; i < 5000 && !acc; i++) begin
      @(negedge clk);
      acc = char_ready;
      tick();
    end
    char_valid = 1'b0;
    if (!acc) chk(1'b0, "send_timeout", 0, 1);
    $display("TX byte=%02h col=%0d row=%0d", b, m_col, m_row);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      tick();
      done = char_ready && (exp_q.size() == 0);
    end
    if (!done) chk(1'b0, "idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_idle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_wr, s_fill, s_low, n;
    bit hit;
    logic [7:0] b;

    // Reset values and release behaviour.
    rst_n = 1'b0;
    repeat (3) tick();
    chk(wea === 1'b0, "rst_wea", int'(wea), 0);
    chk(addra === 12'd0, "rst_addra", int'(addra), 0);
    chk(dina === 8'd0, "rst_dina", int'(dina), 0);
    chk(cursor_col === 7'd0 && cursor_row === 5'd0, "rst_cursor",
        int'(cursor_row) * 100 + int'(cursor_col), 0);
`ifdef CLEAR_ON_RESET_EN
    chk(busy === 1'b1, "rst_busy", int'(busy), 1);
`else
    chk(busy === 1'b0, "rst_busy", int'(busy), 0);
`endif
    s_fill = fill_count;
    rst_n = 1'b1;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      if (char_ready) hit = 1'b1;
      else n++;
      tick();
    end
    chk(hit, "ready_after_reset", int'(hit), 1);
`ifdef CLEAR_ON_RESET_EN
    chk(n >= NCELL, "clear_on_reset_cycles", n, NCELL);
    chk(fill_count - s_fill == NCELL, "clear_on_reset_writes", fill_count - s_fill, NCELL);
`else
    chk(n == 0, "ready_first_cycle", n, 0);
`endif
    wait_idle();

    // "AB"
    s_wr = wr_count;
    send("A"); wait_idle();
    chk(last_addr == 0 && last_data == 8'h41, "ab_first", last_addr * 256 + last_data, 16'h0041);
    send("B"); wait_idle();
    chk(last_addr == 1 && last_data == 8'h42, "ab_second", last_addr * 256 + last_data, 16'h0142);
    chk(wr_count - s_wr == 2, "ab_count", wr_count - s_wr, 2);
    chk(cursor_row == 5'd0 && cursor_col == 7'd2, "ab_cursor",
        int'(cursor_row) * 100 + int'(cursor_col), 2);

    // Line wrap by printable characters.
    do_reset();
    for (int i = 0; i < COLS; i++) send("x");
    send("y"); wait_idle();
    chk(last_addr == 80 && last_data == 8'h79, "wrap_y", last_addr * 256 + last_data, 80 * 256 + 8'h79);
    chk(cursor_row == 5'd1 && cursor_col == 7'd1, "wrap_cursor",
        int'(cursor_row) * 100 + int'(cursor_col), 101);

    // CR, LF, BS at col 0, then z + BS.
    do_reset();
    s_wr = wr_count;
    send(ASCII_CR); send(ASCII_LF); send(ASCII_BS); wait_idle();
    chk(wr_count == s_wr, "ctrl_no_write", wr_count - s_wr, 0);
    chk(cursor_row == 5'd1 && cursor_col == 7'd0, "ctrl_cursor",
        int'(cursor_row) * 100 + int'(cursor_col), 100);
    send("z"); send(ASCII_BS); wait_idle();
    chk(wr_count - s_wr == 2, "bs_count", wr_count - s_wr, 2);
    chk(last_addr == 80 && last_data == 8'h20, "bs_fill", last_addr * 256 + last_data, 80 * 256 + 8'h20);
    chk(cursor_row == 5'd1 && cursor_col == 7'd0, "bs_cursor",
        int'(cursor_row) * 100 + int'(cursor_col), 100);

    // LF on the last row clears row 0; held byte lands at address 0.
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(ASCII_LF);
    wait_idle();
    chk(cursor_row == 5'd29, "row29", int'(cursor_row), 29);
    s_wr = wr_count; s_fill = fill_count; s_low = ready_low_count;
    send(ASCII_LF); send("q"); wait_idle();
    chk(fill_count - s_fill == COLS, "clr_line_fills", fill_count - s_fill, COLS);
    chk(ready_low_count - s_low == COLS, "clr_line_busy", ready_low_count - s_low, COLS);
    chk(wr_count - s_wr == COLS + 1, "clr_line_writes", wr_count - s_wr, COLS + 1);
    chk(last_addr == 0 && last_data == 8'h71, "held_byte", last_addr * 256 + last_data, 8'h71);
    chk(cursor_row == 5'd0 && cursor_col == 7'd1, "held_cursor",
        int'(cursor_row) * 100 + int'(cursor_col), 1);

    // Form feed clears the whole screen.
    send("h"); send("i"); wait_idle();
    s_fill = fill_count; s_low = ready_low_count;
    send(ASCII_FF); wait_idle();
    chk(fill_count - s_fill == NCELL, "ff_fills", fill_count - s_fill, NCELL);
    chk(ready_low_count - s_low == NCELL, "ff_busy", ready_low_count - s_low, NCELL);
    chk(last_addr == NCELL - 1, "ff_last_addr", last_addr, NCELL - 1);
    chk(cursor_row == 5'd0 && cursor_col == 7'd0, "ff_cursor",
        int'(cursor_row) * 100 + int'(cursor_col), 0);

    // Reset in the middle of a screen clear.
    send("k"); wait_idle();
    s_wr = wr_count;
    send(ASCII_FF);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick();
      hit = (wr_count - s_wr >= 1000);
    end
    rst_n = 1'b0;
    tick();
    chk(wea === 1'b0, "abort_wea", int'(wea), 0);
    repeat (3) tick();
    chk(wr_count - s_wr == 1001, "abort_writes", wr_count - s_wr, 1001);
    rst_n = 1'b1;
    wait_idle();

    // Random byte stream against the model.
    for (int t = 0; t < 1500; t++) begin
      n = int'($urandom_range(0, 199));
      if (n < 140)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (n < 160) b = ASCII_LF;
      else if (n < 170) b = ASCII_CR;
      else if (n < 184) b = ASCII_BS;
      else if (n == 184) b = ASCII_FF;
      else if (n < 192) b = 8'($urandom_range(8'h7F, 8'hFF));
      else              b = 8'($urandom_range(0, 7));
      send(b);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
